// File: rtl/riscv_alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// riscv_alu_arbiter_pkg
// Shared definitions for the ALU-sharing arbiter:
//   - ALU operator width and opcodes (the basic ALU's operator encoding)
//   - arbiter FSM state type and the operator driven while the ALU is idle
//   - saturating counter helper for the optional grant statistics
// -----------------------------------------------------------------------------
package riscv_alu_arbiter_pkg;

    localparam int ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 7'b0000010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 7'b0000011;

    // Operator presented to the ALU whenever no operation is executing.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ARB_IDLE_OP = ALU_AND;

    typedef enum logic [1:0] {
        ALU_ARB_IDLE = 2'd0,
        ALU_ARB_EXEC = 2'd1,
        ALU_ARB_RESP = 2'd2
    } alu_arb_state_e;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/riscv_alu_arbiter_rr.sv
// -----------------------------------------------------------------------------
// riscv_rr_arbiter
// Round-robin arbiter: combinational masked priority search starting one
// position after the last winner, producing a one-hot grant and its index.
// The pointer moves to the winner only when grant_en is high.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req           request vector
//   grant_en      strobe: the current grant is being taken
//   grant         one-hot grant (combinational)
//   grant_idx     index of the granted requester
//   grant_any     at least one request is present
// -----------------------------------------------------------------------------
module riscv_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       grant_en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] cand_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             grant_any_s;
    logic [NUM_REQ-1:0] grant_s;

    // Priority search: candidates ptr+1, ptr+2, ... wrapping modulo NUM_REQ,
    // so the previous winner is examined last.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr_r) + i) % NUM_REQ);
            if (!grant_any_s && req[cand_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // One-hot decode of the winning index.
    always_comb begin
        grant_s = '0;
        if (grant_any_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Pointer register: reset value makes requester 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= IDX_W'(NUM_REQ - 1);
        end else if (grant_en && grant_any_s) begin
            ptr_r <= grant_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant     = grant_s;
    assign grant_idx = grant_idx_s;
    assign grant_any = grant_any_s;

endmodule

// File: rtl/riscv_alu_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_alu_arbiter
// Shares one basic ALU between NUM_REQ requesters. A request is granted in
// IDLE (round-robin), its operator/operands are registered, the ALU is run
// from those registers in EXEC (stalling on alu_ready_i), and the registered
// result/compare flag are returned to the owner in RESP.
// Minimum latency: accept at cycle 0, response valid at cycle 2.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_*                 per-requester valid/ready request channel (packed,
//                         requester r at slice r)
//   resp_valid_o/ready_i  per-requester response handshake
//   resp_result_o/cmp_o   shared registered result bus
//   alu_*_o / alu_*_i     connection to the shared ALU
//   grant_cnt_o           (only with RISCV_ALU_ARB_PERF_EN) per-requester
//                         16-bit saturating grant counters
// Optional feature macro: RISCV_ALU_ARB_PERF_EN
// -----------------------------------------------------------------------------
module riscv_alu_arbiter
    import riscv_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ALU_OP_W = ALU_OP_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*ALU_OP_W-1:0] req_operator_i,
    input  logic [NUM_REQ*32-1:0]       req_operand_a_i,
    input  logic [NUM_REQ*32-1:0]       req_operand_b_i,
    input  logic [NUM_REQ*2-1:0]        req_vector_mode_i,
    output logic [NUM_REQ-1:0]          resp_valid_o,
    input  logic [NUM_REQ-1:0]          resp_ready_i,
    output logic [31:0]                 resp_result_o,
    output logic                        resp_cmp_o,
    output logic [ALU_OP_W-1:0]         alu_operator_o,
    output logic [31:0]                 alu_operand_a_o,
    output logic [31:0]                 alu_operand_b_o,
    output logic [1:0]                  alu_vector_mode_o,
    output logic                        alu_ex_ready_o,
    input  logic [31:0]                 alu_result_i,
    input  logic                        alu_cmp_i,
    input  logic                        alu_ready_i
`ifdef RISCV_ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]       grant_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    alu_arb_state_e     state_r;
    alu_arb_state_e     state_n_s;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               grant_any_s;
    logic               grant_take_s;

    logic [ALU_OP_W-1:0] op_r;
    logic [31:0]         opa_r;
    logic [31:0]         opb_r;
    logic [1:0]          mode_r;
    logic [IDX_W-1:0]    owner_r;
    logic [31:0]         result_r;
    logic                cmp_r;

    // Grants are only taken in IDLE; the pointer must not move otherwise.
    assign grant_take_s = (state_r == ALU_ARB_IDLE) && grant_any_s;

    riscv_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid_i),
        .grant_en  (state_r == ALU_ARB_IDLE),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ALU_ARB_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ALU_ARB_IDLE: begin
                if (grant_any_s) begin
                    state_n_s = ALU_ARB_EXEC;
                end else begin
                    state_n_s = ALU_ARB_IDLE;
                end
            end
            ALU_ARB_EXEC: begin
                if (alu_ready_i) begin
                    state_n_s = ALU_ARB_RESP;
                end else begin
                    state_n_s = ALU_ARB_EXEC;
                end
            end
            ALU_ARB_RESP: begin
                // Only the owner's ready completes the response.
                if (resp_ready_i[owner_r]) begin
                    state_n_s = ALU_ARB_IDLE;
                end else begin
                    state_n_s = ALU_ARB_RESP;
                end
            end
            default: begin
                state_n_s = ALU_ARB_IDLE;
            end
        endcase
    end

    // Operand capture at grant, result capture when the ALU completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= ALU_ARB_IDLE_OP;
            opa_r    <= 32'd0;
            opb_r    <= 32'd0;
            mode_r   <= 2'd0;
            owner_r  <= '0;
            result_r <= 32'd0;
            cmp_r    <= 1'b0;
        end else begin
            if (grant_take_s) begin
                op_r    <= req_operator_i[grant_idx_s*ALU_OP_W +: ALU_OP_W];
                opa_r   <= req_operand_a_i[grant_idx_s*32 +: 32];
                opb_r   <= req_operand_b_i[grant_idx_s*32 +: 32];
                mode_r  <= req_vector_mode_i[grant_idx_s*2 +: 2];
                owner_r <= grant_idx_s;
            end
            if ((state_r == ALU_ARB_EXEC) && alu_ready_i) begin
                result_r <= alu_result_i;
                cmp_r    <= alu_cmp_i;
            end
        end
    end

    // Request ready and response valid decode from the registered state.
    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        if (state_r == ALU_ARB_IDLE) begin
            req_ready_o = grant_s;
        end else if (state_r == ALU_ARB_RESP) begin
            resp_valid_o[owner_r] = 1'b1;
        end else begin
            req_ready_o  = '0;
            resp_valid_o = '0;
        end
    end

    // ALU inputs come from the capture registers only while executing; the
    // rest of the time the ALU sees a constant AND of zeros.
    always_comb begin
        alu_operator_o    = ALU_ARB_IDLE_OP;
        alu_operand_a_o   = 32'd0;
        alu_operand_b_o   = 32'd0;
        alu_vector_mode_o = 2'd0;
        alu_ex_ready_o    = 1'b0;
        if (state_r == ALU_ARB_EXEC) begin
            alu_operator_o    = op_r;
            alu_operand_a_o   = opa_r;
            alu_operand_b_o   = opb_r;
            alu_vector_mode_o = mode_r;
            alu_ex_ready_o    = 1'b1;
        end else begin
            alu_ex_ready_o    = 1'b0;
        end
    end

    assign resp_result_o = result_r;
    assign resp_cmp_o    = cmp_r;

`ifdef RISCV_ALU_ARB_PERF_EN
    logic [NUM_REQ*16-1:0] grant_cnt_r;

    // Per-requester saturating grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_r <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (grant_take_s && (grant_idx_s == IDX_W'(r))) begin
                    grant_cnt_r[r*16 +: 16] <= sat_inc16(grant_cnt_r[r*16 +: 16]);
                end
            end
        end
    end

    assign grant_cnt_o = grant_cnt_r;
`endif

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_alu_arbiter
// Self-checking bench: reset values, a table of single operations, directed
// multi-cycle sequences (contention, ALU stall, response backpressure, reset
// mid-EXEC) and a randomized phase against a transaction-level model.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_riscv_alu_arbiter;
    import riscv_alu_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int OPW = ALU_OP_WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*OPW-1:0] req_op;
    logic [N*32-1:0]  req_a;
    logic [N*32-1:0]  req_b;
    logic [N*2-1:0]   req_mode;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready;
    logic [31:0]      resp_result;
    logic             resp_cmp;
    logic [OPW-1:0]   alu_operator;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [1:0]       alu_mode;
    logic             alu_ex_ready;
    logic [31:0]      alu_result;
    logic             alu_cmp;
    logic             alu_rdy;
`ifdef RISCV_ALU_ARB_PERF_EN
    logic [N*16-1:0]  grant_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_alu_arbiter #(.NUM_REQ(N), .ALU_OP_W(OPW)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_operator_i    (req_op),
        .req_operand_a_i   (req_a),
        .req_operand_b_i   (req_b),
        .req_vector_mode_i (req_mode),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_result_o     (resp_result),
        .resp_cmp_o        (resp_cmp),
        .alu_operator_o    (alu_operator),
        .alu_operand_a_o   (alu_a),
        .alu_operand_b_o   (alu_b),
        .alu_vector_mode_o (alu_mode),
        .alu_ex_ready_o    (alu_ex_ready),
        .alu_result_i      (alu_result),
        .alu_cmp_i         (alu_cmp),
        .alu_ready_i       (alu_rdy)
`ifdef RISCV_ALU_ARB_PERF_EN
        ,
        .grant_cnt_o       (grant_cnt)
`endif
    );

    // Behavioural ALU: returns {cmp, result}. Unknown operators give a ^ ~b.
    function automatic logic [32:0] alu_fn(input logic [OPW-1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
        logic lt;
        case (op)
            ALU_ADD:  return {1'b0, a + b};
            ALU_SUB:  return {1'b0, a - b};
            ALU_AND:  return {1'b0, a & b};
            ALU_OR:   return {1'b0, a | b};
            ALU_XOR:  return {1'b0, a ^ b};
            ALU_SLTS: begin lt = ($signed(a) < $signed(b)); return {lt, 31'd0, lt}; end
            ALU_SLTU: begin lt = (a < b); return {lt, 31'd0, lt}; end
            default:  return {1'b0, a ^ ~b};
        endcase
    endfunction

    assign {alu_cmp, alu_result} = alu_fn(alu_operator, alu_a, alu_b);

    function automatic logic [N-1:0] oh(input int r);
        logic [N-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [OPW-1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        req_valid[r]           = 1'b1;
        req_op[r*OPW +: OPW]   = op;
        req_a[r*32 +: 32]      = a;
        req_b[r*32 +: 32]      = b;
        req_mode[r*2 +: 2]     = m;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '1;
        alu_rdy = 1'b1;
        drive_edge();
        drive_edge();
        rst = 1'b0;
    endtask

    // One uncontended operation with the minimum-latency timeline.
    task automatic do_op(input int r, input logic [OPW-1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic cmp);
        drive_edge();
        set_req(r, op, a, b, 2'b10);
        @(negedge clk); chk("c0_req_ready", req_ready, oh(r));
        drive_edge();
        req_valid[r] = 1'b0;
        @(negedge clk);
        chk("c1_ex_ready", alu_ex_ready, 1'b1);
        chk("c1_operator", alu_operator, op);
        chk("c1_operand_a", alu_a, a);
        chk("c1_operand_b", alu_b, b);
        chk("c1_mode", alu_mode, 2'b10);
        chk("c1_no_resp", resp_valid, '0);
        drive_edge();
        @(negedge clk);
        chk("c2_resp_valid", resp_valid, oh(r));
        chk("c2_result", resp_result, res);
        chk("c2_cmp", resp_cmp, cmp);
        drive_edge();
        @(negedge clk);
        chk("c3_resp_done", resp_valid, '0);
        chk("c3_alu_idle_op", alu_operator, ALU_AND);
        chk("c3_alu_idle_a", alu_a, 32'd0);
    endtask

    typedef struct {
        int             r;
        logic [OPW-1:0] op;
        logic [31:0]    a;
        logic [31:0]    b;
        logic [31:0]    res;
        logic           cmp;
    } vec_t;

    vec_t vecs[6];
    logic [OPW-1:0] rnd_ops[7];

    initial begin
        int ng;
        int last;
        int owner;
        int done_cnt;
        bit busy;
        logic [31:0] eres;
        logic ecmp;
        logic [N-1:0] exp_grant;
        logic [N-1:0] drop;

        vecs[0] = '{0, ALU_ADD,  32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{1, ALU_SUB,  32'd10,         32'd3,          32'd7,          1'b0};
        vecs[2] = '{0, ALU_SLTS, 32'hFFFF_FFFF,  32'd1,          32'h1,          1'b1};
        vecs[3] = '{2, ALU_AND,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
        vecs[4] = '{1, ALU_SLTS, 32'd1,          32'hFFFF_FFFF,  32'h0,          1'b0};
        vecs[5] = '{2, 7'h7F,    32'h1234_5678,  32'hFFFF_0000,  32'h1234_A987,  1'b0};
        rnd_ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLTS, 7'h7F};

        req_op = '0; req_a = '0; req_b = '0; req_mode = '0;
        reset_dut();

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_cmp", resp_cmp, 1'b0);
        chk("rst_alu_op", alu_operator, ALU_AND);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_ex_ready", alu_ex_ready, 1'b0);
`ifdef RISCV_ALU_ARB_PERF_EN
        chk("rst_grant_cnt", grant_cnt, '0);
`endif

        // Contention straight after reset: order 0,1,0,1
        drive_edge();
        set_req(0, ALU_ADD, 32'd1, 32'd2, 2'b00);
        set_req(1, ALU_SUB, 32'd10, 32'd3, 2'b00);
        ng = 0;
        for (int c = 0; c < 24 && ng < 4; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                chk("cont_grant_order", req_ready, oh(ng % 2));
                ng++;
            end
            if (resp_valid == oh(1)) chk("cont_sub_result", resp_result, 32'd7);
            if (resp_valid == oh(0)) chk("cont_add_result", resp_result, 32'd3);
            drive_edge();
        end
        chk("cont_grant_count", ng, 4);
        req_valid = '0;
        for (int c = 0; c < 4; c++) drive_edge();

        // Table of single operations
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cmp);
        end

        // ALU stall: alu_ready low for four EXEC cycles
        drive_edge();
        set_req(0, ALU_ADD, 32'd100, 32'd23, 2'b01);
        @(negedge clk); chk("stall_c0_ready", req_ready, oh(0));
        drive_edge();
        req_valid = '0;
        alu_rdy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) drive_edge();
            @(negedge clk);
            chk("stall_ex_ready", alu_ex_ready, 1'b1);
            chk("stall_operand_a", alu_a, 32'd100);
            chk("stall_operand_b", alu_b, 32'd23);
            chk("stall_no_resp", resp_valid, '0);
        end
        drive_edge();
        alu_rdy = 1'b1;
        @(negedge clk); chk("stall_c5_no_resp", resp_valid, '0);
        drive_edge();
        @(negedge clk);
        chk("stall_c6_resp", resp_valid, oh(0));
        chk("stall_c6_result", resp_result, 32'd123);
        drive_edge();

        // Response backpressure; a non-owner ready must be ignored
        drive_edge();
        resp_ready = 3'b010;
        set_req(0, ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 2'b00);
        @(negedge clk); chk("bp_c0_ready", req_ready, oh(0));
        drive_edge();
        req_valid[0] = 1'b0;
        set_req(1, ALU_SUB, 32'd10, 32'd3, 2'b00);
        @(negedge clk); chk("bp_c1_no_grant", req_ready, '0);
        for (int k = 2; k <= 4; k++) begin
            drive_edge();
            @(negedge clk);
            chk("bp_resp_held", resp_valid, oh(0));
            chk("bp_result_held", resp_result, 32'hA5A5_5A5A);
            chk("bp_no_grant", req_ready, '0);
        end
        drive_edge();
        resp_ready = '1;
        @(negedge clk);
        chk("bp_c5_resp", resp_valid, oh(0));
        chk("bp_c5_no_grant", req_ready, '0);
        drive_edge();
        @(negedge clk); chk("bp_c6_grant_r1", req_ready, oh(1));
        drive_edge();
        req_valid = '0;
        drive_edge();
        @(negedge clk);
        chk("bp_r1_resp", resp_valid, oh(1));
        chk("bp_r1_result", resp_result, 32'd7);
        drive_edge();

        // Reset in the middle of EXEC
        drive_edge();
        set_req(0, ALU_ADD, 32'd1, 32'd1, 2'b00);
        @(negedge clk); chk("rx_c0_ready", req_ready, oh(0));
        drive_edge();
        req_valid = '0;
        alu_rdy = 1'b0;
        @(negedge clk); chk("rx_c1_exec", alu_ex_ready, 1'b1);
        drive_edge();
        rst = 1'b1;
        #1;
        chk("rx_ex_ready_cleared", alu_ex_ready, 1'b0);
        chk("rx_alu_op", alu_operator, ALU_AND);
        chk("rx_alu_a", alu_a, 32'd0);
        chk("rx_resp_valid", resp_valid, '0);
        chk("rx_result", resp_result, 32'd0);
        drive_edge();
        rst = 1'b0;
        alu_rdy = 1'b1;
`ifdef RISCV_ALU_ARB_PERF_EN
        chk("rx_grant_cnt_zero", grant_cnt, '0);
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("rx_no_resp", resp_valid, '0);
            drive_edge();
        end
        set_req(0, ALU_ADD, 32'd2, 32'd2, 2'b00);
        set_req(1, ALU_ADD, 32'd3, 32'd3, 2'b00);
        @(negedge clk); chk("rx_first_grant_r0", req_ready, oh(0));
        drive_edge();
        req_valid = '0;
`ifdef RISCV_ALU_ARB_PERF_EN
        @(negedge clk); chk("rx_grant_cnt_r0", grant_cnt[15:0], 16'd1);
`endif
        for (int k = 0; k < 4; k++) drive_edge();

        // Randomized traffic against a transaction-level model
        reset_dut();
        last = N - 1;
        busy = 1'b0;
        owner = 0;
        done_cnt = 0;
        eres = '0;
        ecmp = 1'b0;
        drop = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_edge();
            for (int r = 0; r < N; r++) begin
                if (drop[r]) req_valid[r] = 1'b0;
                if (!req_valid[r] && ($urandom_range(0, 2) == 0)) begin
                    set_req(r, rnd_ops[$urandom_range(0, 6)], $urandom, $urandom,
                            2'($urandom_range(0, 3)));
                end
            end
            drop = '0;
            alu_rdy = ($urandom_range(0, 3) != 0);
            resp_ready = N'($urandom);
            @(negedge clk);
            if (!busy) begin
                chk("rnd_idle_no_resp", resp_valid, '0);
                exp_grant = '0;
                for (int k = 1; k <= N; k++) begin
                    if (exp_grant == '0 && req_valid[(last + k) % N]) begin
                        exp_grant = oh((last + k) % N);
                        owner = (last + k) % N;
                    end
                end
                chk("rnd_grant", req_ready, exp_grant);
                if (exp_grant != '0) begin
                    busy = 1'b1;
                    last = owner;
                    drop[owner] = 1'b1;
                    {ecmp, eres} = alu_fn(req_op[owner*OPW +: OPW],
                                          req_a[owner*32 +: 32], req_b[owner*32 +: 32]);
                end
            end else begin
                chk("rnd_busy_no_grant", req_ready, '0);
                if (resp_valid != '0) begin
                    chk("rnd_resp_owner", resp_valid, oh(owner));
                    chk("rnd_resp_result", resp_result, eres);
                    chk("rnd_resp_cmp", resp_cmp, ecmp);
                    if (resp_ready[owner]) begin
                        busy = 1'b0;
                        done_cnt++;
                    end
                end
            end
        end
        chk("rnd_enough_completed", (done_cnt >= 100), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
